// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM generator.
package pwm_pkg;

  // Counting scheme of the shared timebase.
  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_t;

  // Counter direction; only center-aligned mode ever counts down.
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} pwm_dir_t;

endpackage

// File: rtl/pwm_timebase.sv
// Shared period counter: edge/center counting, direction and boundary detection.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             enable,
  input  logic [WIDTH-1:0] period,
  input  pwm_mode_t        mode,
  output logic [WIDTH-1:0] count,
  output logic             boundary,
  output logic             period_start
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_reg, count_next;
  pwm_dir_t         dir_reg, dir_next;
  logic             at_top;

  assign at_top = (count_reg >= period);

  // Next count/direction; direction is forced up whenever the counter lands on 0.
  always_comb begin
    count_next = '0;
    dir_next   = dir_reg;
    if (mode == PWM_EDGE) begin
      count_next = at_top ? '0 : count_reg + ONE;
    end else if (dir_reg == DIR_UP) begin
      if (at_top) begin
        count_next = (period == '0) ? '0 : period - ONE;
        dir_next   = DIR_DOWN;
      end else begin
        count_next = count_reg + ONE;
      end
    end else begin
      count_next = (count_reg == '0) ? '0 : count_reg - ONE;
    end
    if (count_next == '0) begin
      dir_next = DIR_UP;
    end
  end

  // Counter state; held at 0 going up while idle.
  always_ff @(posedge clk) begin
    if (srst || !enable) begin
      count_reg <= '0;
      dir_reg   <= DIR_UP;
    end else begin
      count_reg <= count_next;
      dir_reg   <= dir_next;
    end
  end

  assign count        = count_reg;
  // The boundary is the last cycle of a period: the counter moves to 0 at its end.
  assign boundary     = enable && (count_next == '0);
  // Combinational so the very first running cycle after enable already flags the start.
  assign period_start = enable && !srst && (count_reg == '0);

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM with shared timebase and shadowed period/mode/duty registers.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int CHANNELS = 4,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                enable_in,
  input  logic [WIDTH-1:0]    period_in,
  input  logic                period_valid,
  input  logic                mode_in,
  input  logic [WIDTH-1:0]    dc_in,
  input  logic [CH_W-1:0]     dc_ch,
  input  logic                dc_valid,
  output logic [WIDTH-1:0]    count_out,
  output logic                period_start,
  output logic [CHANNELS-1:0] sig_out
);

  logic [WIDTH-1:0] period_shadow_reg, period_active_reg;
  pwm_mode_t        mode_shadow_reg, mode_active_reg;
  logic [WIDTH-1:0] count;
  logic             boundary;
  logic             load;

  // Active values are refreshed at each boundary, and continuously while idle.
  assign load = boundary || !enable_in;

  pwm_timebase #(
    .WIDTH(WIDTH)
  ) u_timebase (
    .clk         (clk_in),
    .srst        (rst_in),
    .enable      (enable_in),
    .period      (period_active_reg),
    .mode        (mode_active_reg),
    .count       (count),
    .boundary    (boundary),
    .period_start(period_start)
  );

  // Period/mode shadow and active registers; a write in a load cycle bypasses the shadow.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      period_shadow_reg <= '1;
      period_active_reg <= '1;
      mode_shadow_reg   <= PWM_EDGE;
      mode_active_reg   <= PWM_EDGE;
    end else begin
      if (period_valid) begin
        period_shadow_reg <= period_in;
        mode_shadow_reg   <= pwm_mode_t'(mode_in);
      end
      if (load) begin
        period_active_reg <= period_valid ? period_in : period_shadow_reg;
        mode_active_reg   <= period_valid ? pwm_mode_t'(mode_in) : mode_shadow_reg;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] duty_shadow_reg, duty_active_reg;
      logic             sig_reg;
      logic             wr;

      // Out-of-range channel indices never match any channel, so they write nothing.
      assign wr = dc_valid && (dc_ch == CH_W'(gi));

      // Duty shadow/active registers and the registered compare output.
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          duty_shadow_reg <= '0;
          duty_active_reg <= '0;
          sig_reg         <= 1'b0;
        end else begin
          if (wr) begin
            duty_shadow_reg <= dc_in;
          end
          if (load) begin
            duty_active_reg <= wr ? dc_in : duty_shadow_reg;
          end
          sig_reg <= enable_in && (count < duty_active_reg);
        end
      end

      assign sig_out[gi] = sig_reg;
    end
  endgenerate

  assign count_out = count;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: vector table plus directed corner sequences.
module tb_pwm_multi;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 3;

  logic             clk = 1'b0;
  logic             rst_in = 1'b1;
  logic             enable_in = 1'b0;
  logic [WIDTH-1:0] period_in = '0;
  logic             period_valid = 1'b0;
  logic             mode_in = 1'b0;
  logic [WIDTH-1:0] dc_in = '0;
  logic [1:0]       dc_ch = '0;
  logic             dc_valid = 1'b0;
  logic [WIDTH-1:0] count_out;
  logic             period_start;
  logic [CHANNELS-1:0] sig_out;

  int total  = 0;
  int passed = 0;

  pwm_multi #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .enable_in   (enable_in),
    .period_in   (period_in),
    .period_valid(period_valid),
    .mode_in     (mode_in),
    .dc_in       (dc_in),
    .dc_ch       (dc_ch),
    .dc_valid    (dc_valid),
    .count_out   (count_out),
    .period_start(period_start),
    .sig_out     (sig_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       mode;
    logic [7:0] period;
    logic [7:0] duty;
    int         len;
    int         highs;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Disabled-state programming: period/mode plus one duty write in the same cycle.
  task automatic prog(input logic m, input logic [7:0] p, input logic [1:0] ch, input logic [7:0] d);
    enable_in    = 1'b0;
    period_in    = p;
    mode_in      = m;
    period_valid = 1'b1;
    dc_in        = d;
    dc_ch        = ch;
    dc_valid     = 1'b1;
    step();
    period_valid = 1'b0;
    dc_valid     = 1'b0;
    step();
  endtask

  task automatic dc_write(input logic [1:0] ch, input logic [7:0] d);
    dc_ch    = ch;
    dc_in    = d;
    dc_valid = 1'b1;
    step();
    dc_valid = 1'b0;
  endtask

  initial begin
    int h, p, h1, h2, h3;
    int hc [3];
    int exp_cnt [9];

    //        mode  P    D    len highs
    vecs[0]  = '{1'b0, 8'd9,  8'd3,   10, 3};
    vecs[1]  = '{1'b1, 8'd4,  8'd2,    8, 3};
    vecs[2]  = '{1'b0, 8'd9,  8'd0,   10, 0};
    vecs[3]  = '{1'b0, 8'd9,  8'd10,  10, 10};
    vecs[4]  = '{1'b0, 8'd9,  8'd255, 10, 10};
    vecs[5]  = '{1'b1, 8'd4,  8'd5,    8, 8};
    vecs[6]  = '{1'b0, 8'd0,  8'd0,    1, 0};
    vecs[7]  = '{1'b0, 8'd0,  8'd1,    1, 1};
    vecs[8]  = '{1'b1, 8'd1,  8'd1,    2, 1};
    vecs[9]  = '{1'b0, 8'd5,  8'd5,    6, 5};
    vecs[10] = '{1'b1, 8'd3,  8'd3,    6, 5};

    // Reset held with enable high: everything stays cleared.
    rst_in    = 1'b1;
    enable_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_sig", sig_out, 0);
      check("rst_count", count_out, 0);
      check("rst_ps", period_start, 0);
    end
    $display("reset hold: count=%0d sig=%b ps=%b", count_out, sig_out, period_start);
    rst_in = 1'b0;

    // Table: one full period per configuration on channel 0.
    for (int v = 0; v < 11; v++) begin
      prog(vecs[v].mode, vecs[v].period, 2'd0, vecs[v].duty);
      enable_in = 1'b1;
      #1;
      check("vec_start_count", count_out, 0);
      check("vec_start_ps", period_start, 1);
      h = 0;
      p = 0;
      for (int i = 0; i < vecs[v].len; i++) begin
        step();
        h += int'(sig_out[0]);
        p += int'(period_start);
      end
      check("vec_highs", h, vecs[v].highs);
      check("vec_ps_count", p, 1);
      $display("vec %0d mode=%0d P=%0d D=%0d len=%0d highs=%0d ps=%0d",
               v, vecs[v].mode, vecs[v].period, vecs[v].duty, vecs[v].len, h, p);
    end

    // Center-aligned count sequence for P=4.
    exp_cnt = '{0, 1, 2, 3, 4, 3, 2, 1, 0};
    prog(1'b1, 8'd4, 2'd1, 8'd2);
    enable_in = 1'b1;
    #1;
    h = 0;
    for (int i = 0; i < 9; i++) begin
      check("center_count", count_out, exp_cnt[i]);
      if (i > 0) h += int'(sig_out[1]);
      step();
    end
    h += int'(sig_out[1]);
    check("center_ch1_highs", h - int'(sig_out[1]) + 0, 3);
    $display("center seq: ch1 highs over 8 cycles=%0d", h - int'(sig_out[1]));

    // Mid-period duty write is deferred; a write in the boundary cycle is immediate.
    prog(1'b0, 8'd9, 2'd2, 8'd3);
    enable_in = 1'b1;
    h1 = 0; h2 = 0; h3 = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i <= 10) h1 += int'(sig_out[2]);
      else if (i <= 20) h2 += int'(sig_out[2]);
      else if (i > 30) h3 += int'(sig_out[2]);
      if (i == 4) begin
        dc_ch = 2'd2; dc_in = 8'd7; dc_valid = 1'b1;
      end
      if (i == 5) dc_valid = 1'b0;
      if (i == 29) begin
        check("boundary_count", count_out, 9);
        dc_ch = 2'd2; dc_in = 8'd5; dc_valid = 1'b1;
      end
      if (i == 30) dc_valid = 1'b0;
    end
    check("mid_write_cur", h1, 3);
    check("mid_write_next", h2, 7);
    check("bnd_write_immediate", h3, 5);
    $display("shadow writes: cur=%0d next=%0d boundary=%0d", h1, h2, h3);

    // Out-of-range channel write is dropped.
    prog(1'b0, 8'd9, 2'd0, 8'd2);
    dc_write(2'd1, 8'd4);
    dc_write(2'd2, 8'd6);
    dc_write(2'd3, 8'd9);
    enable_in = 1'b1;
    hc = '{0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      step();
      for (int c = 0; c < 3; c++) hc[c] += int'(sig_out[c]);
    end
    check("bad_ch_ch0", hc[0], 2);
    check("bad_ch_ch1", hc[1], 4);
    check("bad_ch_ch2", hc[2], 6);
    $display("bad channel write: highs=%0d,%0d,%0d", hc[0], hc[1], hc[2]);

    // Enable toggle mid-period.
    step();
    step();
    check("pre_dis_count", count_out, 2);
    check("pre_dis_sig2", sig_out[2], 1);
    enable_in = 1'b0;
    step();
    check("dis_sig", sig_out, 0);
    check("dis_count", count_out, 0);
    check("dis_ps", period_start, 0);
    step();
    step();
    check("dis_hold_count", count_out, 0);
    enable_in = 1'b1;
    #1;
    check("reen_count", count_out, 0);
    check("reen_ps", period_start, 1);
    step();
    check("reen_count1", count_out, 1);
    check("reen_sig2", sig_out[2], 1);
    $display("enable toggle: restart count=%0d sig=%b", count_out, sig_out);

    // Reset mid-period clears everything and restores reset values.
    step();
    step();
    step();
    rst_in = 1'b1;
    step();
    check("midrst_count", count_out, 0);
    check("midrst_sig", sig_out, 0);
    check("midrst_ps", period_start, 0);
    rst_in = 1'b0;
    #1;
    check("postrst_ps", period_start, 1);
    step();
    check("postrst_count", count_out, 1);
    check("postrst_sig", sig_out, 0);
    step();
    check("postrst_sig2", sig_out, 0);
    $display("mid reset: count=%0d sig=%b", count_out, sig_out);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
